// File: rtl/btn_pkg.sv
// Shared definitions for push-button conditioning blocks.
// Debounce FSM states and stability-count limits.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  localparam int MIN_STABLE_CYCLES = 2;
  localparam int DEF_STABLE_CYCLES = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Both stages clear to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: sync, stable-count filter, level,
// single-cycle press/release pulses and a press counter.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic       btn_clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic       btn_release,
  output logic [7:0] press_count
);

  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_min_chk
    $error("STABLE_CYCLES below minimum");
  end
  if (((STABLE_CYCLES - 1) >> CNT_W) != 0) begin : g_cnt_chk
    $error("CNT_W too narrow for STABLE_CYCLES");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             s2;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rel_q, rel_d;
  logic [7:0]       count_q, count_d;

  sync_2ff #(.W(1)) u_sync (
    .clk_i (btn_clk),
    .rst_i (rst),
    .d_i   (btn_raw),
    .q_o   (s2)
  );

  always_ff @(posedge btn_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      rel_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_CHK;
          cnt_d   = ONE;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = REL_CHK;
          cnt_d   = ONE;
        end
      end
      REL_CHK: begin
        // a bounce back to 1 keeps the button held
        if (s2) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_release = rel_q;
  assign press_count = count_q;

endmodule
